// File: rtl/sample_frame_rx.sv
// Receive side of the sine-sample serial link.
// Recovers LSB-first frames (start 0, data bits, stop bits of 1, idle high)
// by oversampling rx, widens each sample to the 12-bit DAC word as
// {data, zeros}, and offers it downstream on a valid/ready handshake.
`timescale 1ns/1ps
module sample_frame_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [11:0] sample,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam int CNT_W   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);
    localparam int PAD     = 12 - DATA_BITS;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic [11:0]          sample_new;

    // Received data left-justified into the DAC word, low bits zero.
    assign sample_new = 12'(shreg) << PAD;

    assign busy = (state != S_IDLE);

    // Two-flop synchronizer for the asynchronous line, preset to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM with bit timing, shift register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == CNT_MID) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= DATA_BITS'({rx_s, shreg} >> 1);
                        if (idx == DATA_LAST) begin
                            idx   <= '0;
                            state <= S_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            idx       <= '0;
                            state     <= S_BREAK;
                        end else if (idx == STOP_LAST) begin
                            idx   <= '0;
                            state <= S_IDLE;
                            if (!sample_valid || sample_ready) begin
                                sample       <= sample_new;
                                sample_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (!rx_s) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_frame_rx.sv
// Self-checking bench for sample_frame_rx: directed scenarios plus random
// frame streams at nominal and +/-3% bit periods, scored against a simple
// queue-based model of the delivered DAC words.
`timescale 1ns/1ps
module tb_sample_frame_rx;

    localparam int CLKS_PER_BIT = 16;
    localparam int DATA_BITS    = 8;
    localparam int STOP_BITS    = 3;
    localparam int FRAME_BITS   = 1 + DATA_BITS + STOP_BITS;
    localparam int LATENCY      = 187;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        sample_ready;
    logic [11:0] sample;
    logic        sample_valid;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          fe_count = 0;
    int          ov_count = 0;
    bit          busy_seen = 1'b0;
    logic [11:0] got_q[$];
    int          got_cyc[$];
    logic [11:0] exp_q[$];

    sample_frame_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_BITS   (DATA_BITS),
        .STOP_BITS   (STOP_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Free-running edge counter used for latency measurement.
    always @(posedge clk) cyc++;

    // Observe outputs mid-cycle: log accepted samples and count pulses.
    always @(negedge clk) begin
        if (sample_valid && sample_ready) begin
            got_q.push_back(sample);
            got_cyc.push_back(cyc);
        end
        if (frame_err) fe_count++;
        if (overrun) ov_count++;
        if (busy) busy_seen = 1'b1;
    end

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Expected DAC word: data scaled up into the top bits of 12.
    function automatic logic [11:0] modelSample(input int data);
        return 12'(data * (1 << (12 - DATA_BITS)));
    endfunction

    // Drive one frame; per100 is the bit period in hundredths of a clock.
    task automatic applyStimulus(input logic [DATA_BITS-1:0] data,
                                 input logic [STOP_BITS-1:0] stop_mask,
                                 input int per100, input int gap,
                                 output int start_cyc);
        logic [FRAME_BITS-1:0] frame;
        int elapsed;
        frame     = {stop_mask, data, 1'b0};
        elapsed   = 0;
        start_cyc = cyc;
        for (int n = 0; n < FRAME_BITS; n++) begin
            int bit_end;
            bit_end = ((n + 1) * per100 + 50) / 100;
            rx = frame[n];
            while (elapsed < bit_end) begin
                tick(1);
                elapsed++;
            end
        end
        rx = 1'b1;
        tick(gap);
    endtask

    task automatic waitAccepts(input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    task automatic checkScoreboard(input string tag);
        int n;
        checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_item%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        int s;
        int fe0;
        int ov0;
        int lat;
        int periods[3];
        logic [7:0] d;

        periods[0] = 1600;
        periods[1] = 1552;
        periods[2] = 1648;

        rst          = 1'b1;
        rx           = 1'b1;
        sample_ready = 1'b1;
        tick(3);
        checkOutput("reset_sample", sample, 12'h000);
        checkOutput("reset_valid", sample_valid, 1'b0);
        checkOutput("reset_frame_err", frame_err, 1'b0);
        checkOutput("reset_overrun", overrun, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        rst = 1'b0;
        tick(5);

        $display("[TB] good frame 0xA5 with latency");
        fe0 = fe_count;
        ov0 = ov_count;
        applyStimulus(8'hA5, 3'b111, 1600, 0, s);
        exp_q.push_back(modelSample(8'hA5));
        waitAccepts(1, 100);
        lat = (got_cyc.size() > 0) ? got_cyc[0] - s : -1;
        checkOutput("t1_latency", lat, LATENCY);
        checkScoreboard("t1");
        checkOutput("t1_frame_err", fe_count - fe0, 0);
        checkOutput("t1_overrun", ov_count - ov0, 0);

        $display("[TB] start-bit glitch");
        busy_seen = 1'b0;
        fe0 = fe_count;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(30);
        checkOutput("t2_busy_seen", busy_seen, 1'b1);
        checkOutput("t2_busy_idle", busy, 1'b0);
        checkOutput("t2_no_valid", got_q.size(), 0);
        checkOutput("t2_frame_err", fe_count - fe0, 0);

        $display("[TB] bad stop bit then good frame");
        fe0 = fe_count;
        applyStimulus(8'h5A, 3'b101, 1600, 40, s);
        checkOutput("t3_frame_err", fe_count - fe0, 1);
        checkOutput("t3_no_valid", got_q.size(), 0);
        checkOutput("t3_valid_low", sample_valid, 1'b0);
        applyStimulus(8'h3C, 3'b111, 1600, 20, s);
        exp_q.push_back(modelSample(8'h3C));
        waitAccepts(1, 100);
        checkScoreboard("t3");

        $display("[TB] overrun with ready low");
        sample_ready = 1'b0;
        ov0 = ov_count;
        applyStimulus(8'hA5, 3'b111, 1600, 0, s);
        applyStimulus(8'h11, 3'b111, 1600, 20, s);
        checkOutput("t4_overrun", ov_count - ov0, 1);
        checkOutput("t4_sample_held", sample, 12'hA50);
        checkOutput("t4_valid_held", sample_valid, 1'b1);
        checkOutput("t4_no_accept", got_q.size(), 0);
        sample_ready = 1'b1;
        exp_q.push_back(modelSample(8'hA5));
        tick(1);
        checkOutput("t4_valid_drop", sample_valid, 1'b0);
        checkScoreboard("t4");

        $display("[TB] reset mid-frame");
        rx = 1'b0;
        tick(16);
        rx = 1'b1;
        tick(40);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("t5_sample", sample, 12'h000);
        checkOutput("t5_valid", sample_valid, 1'b0);
        checkOutput("t5_busy", busy, 1'b0);
        checkOutput("t5_frame_err", frame_err, 1'b0);
        checkOutput("t5_overrun", overrun, 1'b0);
        tick(200);
        applyStimulus(8'h81, 3'b111, 1600, 20, s);
        exp_q.push_back(modelSample(8'h81));
        waitAccepts(1, 100);
        checkScoreboard("t5");

        for (int p = 0; p < 3; p++) begin
            $display("[TB] random stream, period %0d/100 clocks", periods[p]);
            fe0 = fe_count;
            ov0 = ov_count;
            for (int k = 0; k < 20; k++) begin
                d = 8'($urandom_range(0, 255));
                applyStimulus(d, 3'b111, periods[p], 0, s);
                exp_q.push_back(modelSample(int'(d)));
            end
            waitAccepts(20, 200);
            checkScoreboard($sformatf("t6_p%0d", periods[p]));
            checkOutput($sformatf("t6_p%0d_frame_err", periods[p]), fe_count - fe0, 0);
            checkOutput($sformatf("t6_p%0d_overrun", periods[p]), ov_count - ov0, 0);
            tick(20);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
